// File: rtl/tl_pkg.sv
// tl_pkg: phase encoding and per-approach lamp decode shared by the intersection controller.
package tl_pkg;
  typedef enum logic [2:0] {ALL_RED = 3'd0, REDYLW = 3'd1, GREEN = 3'd2, YELLOW = 3'd3, FLASH = 3'd4} phase_e;
  typedef struct packed {logic r; logic y; logic g;} lamp_t;
  function automatic lamp_t lamp_of(phase_e p, logic sel, logic fl);
    lamp_t l;
    l = 3'b100;
    case (p)
      REDYLW: l.y = sel;
      GREEN: l = sel ? 3'b001 : 3'b100;
      YELLOW: l = sel ? 3'b010 : 3'b100;
      FLASH: l = {1'b0, fl, 1'b0};
      default: l = 3'b100;
    endcase
    return l;
  endfunction
endpackage

// File: rtl/tl_if.sv
// tl_if: inputs and lamp outputs of the intersection controller.
// Defining TL_PED_EN adds the pedestrian ped_req/walk signals.
interface tl_if
  import tl_pkg::*;
#(
  parameter int N_APPR = 2
);
  localparam int IW = $clog2(N_APPR);
  logic en, flash_req;
  logic [N_APPR-1:0] demand, red, yellow, green;
  logic [IW-1:0] active_idx;
  phase_e phase;
`ifdef TL_PED_EN
  logic [N_APPR-1:0] ped_req, walk;
  modport master(input en, flash_req, demand, ped_req, output red, yellow, green, active_idx, phase, walk);
  modport slave(output en, flash_req, demand, ped_req, input red, yellow, green, active_idx, phase, walk);
`else
  modport master(input en, flash_req, demand, output red, yellow, green, active_idx, phase);
  modport slave(output en, flash_req, demand, input red, yellow, green, active_idx, phase);
`endif
endinterface

// File: rtl/tl_timer.sv
// tl_timer: loadable down-counter; expired flags the last cycle of a phase.
module tl_timer #(
  parameter int TW = 8,
  parameter logic [TW-1:0] RST_VAL = TW'(1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expired
);
  logic [TW-1:0] value_q, value_d;
  always_comb value_d = load ? load_val : en ? value_q - TW'(1) : value_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value_q <= RST_VAL;
    else value_q <= value_d;
  assign expired = value_q == TW'(1);
endmodule

// File: rtl/traffic_intersection.sv
// traffic_intersection: N-approach round-robin signal controller with flashing-yellow mode.
// Defining TL_PED_EN adds sticky pedestrian requests and per-approach walk lamps.
module traffic_intersection
  import tl_pkg::*;
#(
  parameter int N_APPR   = 2,
  parameter int REDYLW_T = 2,
  parameter int GREEN_T  = 6,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int FLASH_T  = 4,
  parameter int TW       = 8
) (
  input logic  clk,
  input logic  rst_n,
  tl_if.master bus
);
  localparam int IW = $clog2(N_APPR);
  phase_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, nxt_idx;
  logic flash_q, flash_d, expired, step;
  logic [TW-1:0] load_val;
  logic [N_APPR-1:0] dem, sel_oh, red_q, red_d, yellow_q, yellow_d, green_q, green_d;
`ifdef TL_PED_EN
  logic [N_APPR-1:0] ped_q, ped_d, ped_clr, walk_q, walk_d;
  assign dem = bus.demand | ped_q;
`else
  assign dem = bus.demand;
`endif
  assign step = bus.en && expired;
  assign sel_oh = N_APPR'(1) << idx_q;
  tl_timer #(.TW(TW), .RST_VAL(TW'(ALLRED_T))) u_timer (
    .clk(clk), .rst_n(rst_n), .en(bus.en), .load(step), .load_val(load_val), .expired(expired)
  );
  // Descending scan so the nearest requesting approach after idx_q wins.
  always_comb begin
    nxt_idx = IW'((int'(idx_q) + 1) % N_APPR);
    for (int k = N_APPR; k >= 1; k--)
      if (dem[(int'(idx_q) + k) % N_APPR]) nxt_idx = IW'((int'(idx_q) + k) % N_APPR);
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    flash_d = flash_q;
    load_val = TW'(ALLRED_T);
`ifdef TL_PED_EN
    walk_d = walk_q;
    ped_clr = '0;
`endif
    if (step)
      case (state_q)
        ALL_RED: begin
          state_d = bus.flash_req ? FLASH : REDYLW;
          idx_d = bus.flash_req ? idx_q : nxt_idx;
          flash_d = 1'b1;
          load_val = bus.flash_req ? TW'(FLASH_T) : TW'(REDYLW_T);
        end
        REDYLW: begin
          state_d = GREEN;
          load_val = TW'(GREEN_T);
`ifdef TL_PED_EN
          walk_d = sel_oh & ped_q;
          ped_clr = sel_oh;
`endif
        end
        GREEN: begin
          // Extend only while this approach is the sole one with demand.
          state_d = (!bus.flash_req && dem != '0 && (dem & ~sel_oh) == '0) ? GREEN : YELLOW;
          load_val = state_d == GREEN ? TW'(GREEN_T) : TW'(YELLOW_T);
`ifdef TL_PED_EN
          walk_d = '0;
`endif
        end
        YELLOW: state_d = ALL_RED;
        FLASH: begin
          state_d = bus.flash_req ? FLASH : ALL_RED;
          flash_d = !flash_q;
          load_val = bus.flash_req ? TW'(FLASH_T) : TW'(ALLRED_T);
        end
        default: state_d = ALL_RED;
      endcase
  end
  for (genvar i = 0; i < N_APPR; i++) begin : g_lamp
    lamp_t l;
    assign l = lamp_of(state_d, idx_d == IW'(i), flash_d);
    assign red_d[i] = l.r;
    assign yellow_d[i] = l.y;
    assign green_d[i] = l.g;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ALL_RED;
      idx_q <= IW'(N_APPR - 1);
      flash_q <= 1'b0;
      red_q <= '1;
      yellow_q <= '0;
      green_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      flash_q <= flash_d;
      red_q <= red_d;
      yellow_q <= yellow_d;
      green_q <= green_d;
    end
`ifdef TL_PED_EN
  assign ped_d = (ped_q & ~ped_clr) | bus.ped_req;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ped_q <= '0;
      walk_q <= '0;
    end else begin
      ped_q <= ped_d;
      walk_q <= walk_d;
    end
  assign bus.walk = walk_q;
`endif
  assign bus.red = red_q;
  assign bus.yellow = yellow_q;
  assign bus.green = green_q;
  assign bus.active_idx = idx_q;
  assign bus.phase = state_q;
endmodule

// File: tb/tb_traffic_intersection.sv
// tb_traffic_intersection: segment-queue reference model of the intersection schedule.
module tb_traffic_intersection;
  import tl_pkg::*;
  localparam int N = 2, IW = $clog2(N), RY = 2, GT = 6, YT = 2, AR = 1, FT = 4, VW = 4 * N + 3 + IW;
  logic clk = 1'b0, rst_n = 1'b1, armed = 1'b0;
  int tests = 0, fails = 0, nro = 0;
  always #5 clk = ~clk;

  tl_if #(.N_APPR(N)) bus();
  traffic_intersection #(.N_APPR(N), .REDYLW_T(RY), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AR),
    .FLASH_T(FT), .TW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {phase_e ph; int idx; logic fl; logic [N-1:0] r, y, g, w;} rec_t;
  rec_t q[$];
  rec_t cur;
  logic [N-1:0] latch, m_dem, m_clr;

  // Expected outputs are queued one entry per clock of each phase.
  function automatic void seg(phase_e ph, int idx, logic fl, logic [N-1:0] w, int len);
    rec_t e;
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    e.ph = ph; e.idx = idx; e.fl = fl; e.w = w;
    e.r = (ph == FLASH) ? '0 : (ph == GREEN || ph == YELLOW) ? ~oh : '1;
    e.y = (ph == FLASH) ? {N{fl}} : (ph == REDYLW || ph == YELLOW) ? oh : '0;
    e.g = (ph == GREEN) ? oh : '0;
    repeat (len) q.push_back(e);
  endfunction

  function automatic int rr(int idx, logic [N-1:0] d);
    for (int k = 1; k <= N; k++) if (d[(idx + k) % N]) return (idx + k) % N;
    return (idx + 1) % N;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
      seg(ALL_RED, N - 1, 1'b0, '0, AR);
      cur = q[0];
      latch = '0;
    end else begin
      m_clr = '0;
`ifdef TL_PED_EN
      m_dem = bus.demand | latch;
`else
      m_dem = bus.demand;
`endif
      if (bus.en) begin
        cur = q.pop_front();
        if (q.size() == 0)
          case (cur.ph)
            ALL_RED: if (bus.flash_req) seg(FLASH, cur.idx, 1'b1, '0, FT);
                     else seg(REDYLW, rr(cur.idx, m_dem), 1'b0, '0, RY);
            REDYLW: begin
              m_clr = N'(1) << cur.idx;
              seg(GREEN, cur.idx, 1'b0, latch & m_clr, GT);
            end
            GREEN: if (!bus.flash_req && m_dem != 0 && (m_dem & ~(N'(1) << cur.idx)) == 0)
                     seg(GREEN, cur.idx, 1'b0, '0, GT);
                   else seg(YELLOW, cur.idx, 1'b0, '0, YT);
            YELLOW: seg(ALL_RED, cur.idx, 1'b0, '0, AR);
            default: if (bus.flash_req) seg(FLASH, cur.idx, !cur.fl, '0, FT);
                     else seg(ALL_RED, cur.idx, 1'b0, '0, AR);
          endcase
      end
`ifdef TL_PED_EN
      latch = (latch & ~m_clr) | bus.ped_req;
`endif
    end

  function automatic logic [VW-1:0] got();
    logic [N-1:0] w;
    w = '0;
`ifdef TL_PED_EN
    w = bus.walk;
`endif
    return {bus.red, bus.yellow, bus.green, bus.phase, bus.active_idx, w};
  endfunction

  function automatic logic [VW-1:0] want();
    return {q[0].r, q[0].y, q[0].g, q[0].ph, IW'(q[0].idx), q[0].w};
  endfunction

  always @(negedge clk)
    if (armed && rst_n) begin
      nro = 0;
      for (int i = 0; i < N; i++) nro += int'(!(bus.red[i] && !bus.yellow[i] && !bus.green[i]));
      tests++;
      if ($isunknown({bus.red, bus.yellow, bus.green}) || !$onehot0(bus.green) || (bus.phase != FLASH && nro > 1)) begin
        fails++;
        $display("FAIL safety t=%0t got r=%b y=%b g=%b, required at most one non-red approach and one-hot green", $time, bus.red, bus.yellow, bus.green);
      end
    end

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    armed = 1'b1;
    tests++;
    if ({bus.red, bus.yellow, bus.green, bus.phase, bus.active_idx} !== {{N{1'b1}}, {N{1'b0}}, {N{1'b0}}, ALL_RED, IW'(N - 1)}) begin
      fails++;
      $display("FAIL reset_state got r=%b y=%b g=%b ph=%0d idx=%0d", bus.red, bus.yellow, bus.green, bus.phase, bus.active_idx);
    end
    tests++;
    if (got() !== want()) begin fails++; $display("FAIL reset_model got %h want %h", got(), want()); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cycle(input string name, input logic [N-1:0] d);
    int c0 = 0, c1 = 0;
    bus.demand = d;
    reset_dut();
    repeat (33) begin
      @(negedge clk);
      tests++;
      if (got() !== want()) begin fails++; $display("FAIL %s t=%0t got %h want %h", name, $time, got(), want()); end
      c0 += int'(bus.green[0]);
      c1 += int'(bus.green[1]);
    end
    tests++;
    if (c0 != 2 * GT || c1 != GT) begin
      fails++;
      $display("FAIL %s_green_cycles got %0d/%0d want %0d/%0d", name, c0, c1, 2 * GT, GT);
    end
  endtask

  task automatic test_extend();
    int c0 = 0;
    logic g1 = 1'b0;
    bus.demand = 2'b01;
    reset_dut();
    repeat (40) begin
      @(negedge clk);
      tests++;
      if (got() !== want()) begin fails++; $display("FAIL extend t=%0t got %h want %h", $time, got(), want()); end
      c0 += int'(bus.green[0]);
      g1 |= bus.green[1];
    end
    tests++;
    if (c0 != 40 - RY || g1) begin fails++; $display("FAIL extend_green got %0d/%b want %0d/0", c0, g1, 40 - RY); end
  endtask

  task automatic test_flash();
    int k = 0, yc = 0;
    bus.demand = '1;
    reset_dut();
    while (k < 20 && !bus.green[0]) begin
      @(negedge clk); k++;
      tests++;
      if (got() !== want()) begin fails++; $display("FAIL flash_pre t=%0t got %h want %h", $time, got(), want()); end
    end
    tests++;
    if (!bus.green[0]) begin fails++; $display("FAIL flash_wait_green got %b want 1", bus.green[0]); end
    bus.flash_req = 1'b1;
    k = 0;
    while (k < 30 && bus.phase != FLASH) begin
      @(negedge clk); k++;
      tests++;
      if (got() !== want()) begin fails++; $display("FAIL flash_enter t=%0t got %h want %h", $time, got(), want()); end
    end
    tests++;
    if (bus.phase != FLASH) begin fails++; $display("FAIL flash_wait_phase got %0d want %0d", bus.phase, FLASH); end
    repeat (4 * FT) begin
      tests++;
      if (got() !== want()) begin fails++; $display("FAIL flash_run t=%0t got %h want %h", $time, got(), want()); end
      yc += int'(bus.yellow == '1);
      @(negedge clk);
    end
    tests++;
    if (yc != 2 * FT) begin fails++; $display("FAIL flash_duty got %0d want %0d", yc, 2 * FT); end
    bus.flash_req = 1'b0;
    k = 0;
    while (k < 40 && bus.green == '0) begin
      @(negedge clk); k++;
      tests++;
      if (got() !== want()) begin fails++; $display("FAIL flash_exit t=%0t got %h want %h", $time, got(), want()); end
    end
    tests++;
    if (bus.green !== 2'b10) begin fails++; $display("FAIL flash_next_appr got %b want 10", bus.green); end
  endtask

  task automatic test_freeze_reset();
    int k = 0, cnt = 0;
    logic done = 1'b0;
    bus.demand = '1;
    reset_dut();
    while (k < 20 && !bus.green[0]) begin @(negedge clk); k++; end
    for (int j = 0; j < 30; j++) begin
      if (bus.green[0] && !done) cnt++;
      if (!bus.green[0] && cnt > 0) done = 1'b1;
      bus.en = !(j >= 2 && j < 7);
      @(negedge clk);
      tests++;
      if (got() !== want()) begin fails++; $display("FAIL freeze t=%0t got %h want %h", $time, got(), want()); end
    end
    bus.en = 1'b1;
    tests++;
    if (cnt != GT + 5) begin fails++; $display("FAIL freeze_green_len got %0d want %0d", cnt, GT + 5); end
    k = 0;
    while (k < 30 && bus.yellow == '0) begin @(negedge clk); k++; end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.red, bus.yellow, bus.green, bus.phase} !== {{N{1'b1}}, {N{1'b0}}, {N{1'b0}}, ALL_RED} || got() !== want()) begin
      fails++;
      $display("FAIL async_reset got r=%b y=%b g=%b ph=%0d", bus.red, bus.yellow, bus.green, bus.phase);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef TL_PED_EN
  task automatic test_ped();
    int k = 0, wc = 0;
    logic g1 = 1'b0;
    bus.demand = 2'b01;
    reset_dut();
    while (k < 20 && !bus.green[0]) begin @(negedge clk); k++; end
    bus.ped_req = 2'b10;
    @(negedge clk);
    bus.ped_req = '0;
    repeat (40) begin
      tests++;
      if (got() !== want()) begin fails++; $display("FAIL ped t=%0t got %h want %h", $time, got(), want()); end
      wc += int'(bus.walk[1]);
      g1 |= bus.green[1];
      @(negedge clk);
    end
    tests++;
    if (wc != GT || !g1) begin fails++; $display("FAIL ped_walk got %0d/%b want %0d/1", wc, g1, GT); end
  endtask
`endif

  task automatic test_random();
    reset_dut();
    repeat (400) begin
      @(negedge clk);
      tests++;
      if (got() !== want()) begin fails++; $display("FAIL random t=%0t got %h want %h", $time, got(), want()); end
      bus.demand = N'($urandom);
      bus.en = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 19) == 0) bus.flash_req = !bus.flash_req;
`ifdef TL_PED_EN
      bus.ped_req = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
`endif
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (got() !== want()) begin fails++; $display("FAIL random_reset got %h want %h", got(), want()); end
        #1 rst_n = 1'b1;
      end
    end
    bus.flash_req = 1'b0;
    bus.en = 1'b1;
  endtask

  initial begin
    bus.en = 1'b1;
    bus.flash_req = 1'b0;
    bus.demand = '0;
`ifdef TL_PED_EN
    bus.ped_req = '0;
`endif
    #1;
    test_reset();
    test_cycle("all_demand", 2'b11);
    test_extend();
    test_cycle("no_demand", 2'b00);
    test_flash();
    test_freeze_reset();
`ifdef TL_PED_EN
    test_ped();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
